// File: rtl/ew_update_sched_if.sv
// Bus bundle between the requesters, the EMA update stage and the scheduler.
// Carries the per-requester tile request, the issue port to the update stage,
// the s_new result port from the update stage and the per-requester response.
// slave : scheduler view.
// master: environment view (requesters plus update stage).
interface ew_update_sched_if #(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned TILE_SIZE = 4,
  parameter int unsigned W         = 16,
  parameter int unsigned S_ADDR_W  = 10
);
  localparam int unsigned TILE_W = TILE_SIZE * W;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*TILE_W-1:0] req_lam;
  logic [N_REQ*TILE_W-1:0] req_u;

  logic                    upd_valid;
  logic                    upd_ready;
  logic [TILE_W-1:0]       upd_lam;
  logic [TILE_W-1:0]       upd_u;
  logic [S_ADDR_W-1:0]     upd_addr;

  logic                    res_valid;
  logic                    res_ready;
  logic [TILE_W-1:0]       res_s;

  logic [N_REQ-1:0]        rsp_valid;
  logic [N_REQ-1:0]        rsp_ready;
  logic [TILE_W-1:0]       rsp_s;

  modport slave (
    input  req_valid, req_lam, req_u, upd_ready, res_valid, res_s, rsp_ready,
    output req_ready, upd_valid, upd_lam, upd_u, upd_addr, res_ready, rsp_valid, rsp_s
  );

  modport master (
    output req_valid, req_lam, req_u, upd_ready, res_valid, res_s, rsp_ready,
    input  req_ready, upd_valid, upd_lam, upd_u, upd_addr, res_ready, rsp_valid, rsp_s
  );
endinterface

// File: rtl/ew_update_sched.sv
// Round-robin scheduler sharing one EMA update stage between N_REQ requesters.
// Generates per-requester state addresses, tracks tile/timestep counters, tags
// each issued tile with its requester ID and routes results back in order.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : request / issue / result / response bundle (slave view)
//   cfg_clear   : level request to clear counters and RR pointer after drain
//   step_done   : per-requester one-cycle pulse on timestep completion
//   step_cnt    : packed per-requester completed-timestep counters
//   busy        : issue register or in-flight ID FIFO occupied
module ew_update_sched #(
  parameter int unsigned TILE_SIZE      = 4,
  parameter int unsigned W              = 16,
  parameter int unsigned S_ADDR_W       = 10,
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TILES_PER_STEP = 16,
  parameter int unsigned STEP_W         = 16,
  parameter int unsigned OUTSTANDING    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ew_update_sched_if.slave        bus,
  input  logic                    cfg_clear,
  output logic [N_REQ-1:0]        step_done,
  output logic [N_REQ*STEP_W-1:0] step_cnt,
  output logic                    busy
);
  localparam int unsigned TILE_W = TILE_SIZE * W;
  localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W  = (TILES_PER_STEP > 1) ? $clog2(TILES_PER_STEP) : 1;
  localparam int unsigned PTR_W  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned DEPTH  = 1 << PTR_W;

  logic [ID_W-1:0]     r_rr;
  logic [CNT_W-1:0]    r_tile_cnt [N_REQ];
  logic [STEP_W-1:0]   r_step_cnt [N_REQ];
  logic [N_REQ-1:0]    r_step_done;

  logic                r_upd_valid;
  logic [TILE_W-1:0]   r_upd_lam;
  logic [TILE_W-1:0]   r_upd_u;
  logic [S_ADDR_W-1:0] r_upd_addr;

  logic [ID_W-1:0]     r_fifo [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [OCC_W-1:0]    r_occ;

  logic                w_gnt_vld;
  logic [ID_W-1:0]     w_gnt;
  logic [31:0]         w_scan;
  logic                w_empty;
  logic                w_full_blk;
  logic                w_load;
  logic                w_push;
  logic                w_pop;
  logic [ID_W-1:0]     w_head;
  logic                w_res_ready;
  logic                w_clear_go;
  logic [ID_W-1:0]     w_rr_nxt;
  logic [S_ADDR_W-1:0] w_addr;

  // Round-robin grant: first valid requester at or after the RR pointer.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_scan    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_scan = (32'(r_rr) + 32'(i)) % N_REQ;
      if (!w_gnt_vld && bus.req_valid[ID_W'(w_scan)]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ID_W'(w_scan);
      end
    end
  end

  assign w_empty     = (r_occ == '0);
  assign w_head      = r_fifo[r_rd_ptr];
  assign w_res_ready = !w_empty && bus.rsp_ready[w_head];
  assign w_pop       = bus.res_valid && w_res_ready;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_full_blk  = (r_occ == OCC_W'(OUTSTANDING)) && !w_pop;
  assign w_load      = (!r_upd_valid || bus.upd_ready) && !w_full_blk && !cfg_clear;
  assign w_push      = w_load && w_gnt_vld;
  assign w_clear_go  = cfg_clear && !r_upd_valid && w_empty;
  assign w_rr_nxt    = (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + ID_W'(1);
  assign w_addr      = S_ADDR_W'(32'(w_gnt) * TILES_PER_STEP + 32'(r_tile_cnt[w_gnt]));

  // One-hot accept toward the granted requester and response toward the head ID.
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    if (w_push) bus.req_ready[w_gnt] = 1'b1;
    if (bus.res_valid && !w_empty) bus.rsp_valid[w_head] = 1'b1;
  end

  assign bus.res_ready = w_res_ready;
  assign bus.rsp_s     = bus.res_s;
  assign bus.upd_valid = r_upd_valid;
  assign bus.upd_lam   = r_upd_lam;
  assign bus.upd_u     = r_upd_u;
  assign bus.upd_addr  = r_upd_addr;
  assign busy          = r_upd_valid || !w_empty;
  assign step_done     = r_step_done;

  always_comb begin
    step_cnt = '0;
    for (int r = 0; r < N_REQ; r++) step_cnt[r*STEP_W +: STEP_W] = r_step_cnt[r];
  end

  // Issue register toward the update stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_valid <= 1'b0;
      r_upd_lam   <= '0;
      r_upd_u     <= '0;
      r_upd_addr  <= '0;
    end else if (w_push) begin
      r_upd_valid <= 1'b1;
      r_upd_lam   <= bus.req_lam[32'(w_gnt)*TILE_W +: TILE_W];
      r_upd_u     <= bus.req_u[32'(w_gnt)*TILE_W +: TILE_W];
      r_upd_addr  <= w_addr;
    end else if (bus.upd_ready) begin
      r_upd_valid <= 1'b0;
    end
  end

  // In-flight requester-ID FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_gnt;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_push && w_pop) r_occ <= r_occ - OCC_W'(1);
    end
  end

  // RR pointer, tile/timestep counters and drained clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr        <= '0;
      r_step_done <= '0;
      for (int r = 0; r < N_REQ; r++) begin
        r_tile_cnt[r] <= '0;
        r_step_cnt[r] <= '0;
      end
    end else begin
      r_step_done <= '0;
      if (w_clear_go) begin
        r_rr <= '0;
        for (int r = 0; r < N_REQ; r++) begin
          r_tile_cnt[r] <= '0;
          r_step_cnt[r] <= '0;
        end
      end else if (w_push) begin
        r_rr <= w_rr_nxt;
        if (r_tile_cnt[w_gnt] == CNT_W'(TILES_PER_STEP - 1)) begin
          r_tile_cnt[w_gnt]  <= '0;
          r_step_cnt[w_gnt]  <= r_step_cnt[w_gnt] + STEP_W'(1);
          r_step_done[w_gnt] <= 1'b1;
        end else begin
          r_tile_cnt[w_gnt] <= r_tile_cnt[w_gnt] + CNT_W'(1);
        end
      end
    end
  end

  // A result with no tagged tile outstanding has no owner.
  a_res_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.res_valid && w_empty));

endmodule

// File: tb/tb_ew_update_sched.sv
module tb_ew_update_sched;
  localparam int unsigned N_REQ = 2;
  localparam logic [63:0] LAM0 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] LAM1 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] U0   = 64'hAAAA_0001_AAAA_0002;
  localparam logic [63:0] U1   = 64'hBBBB_0003_BBBB_0004;
  localparam logic [63:0] RS   = 64'hDEAD_BEEF_0123_4567;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_clear;
  logic [1:0]  step_done;
  logic [31:0] step_cnt;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit auto_stage;
  logic [63:0] stage_q[$];
  logic [9:0]  exp_addr[6];
  logic [1:0]  exp_gnt[6];

  ew_update_sched_if #(.N_REQ(N_REQ), .TILE_SIZE(4), .W(16), .S_ADDR_W(10)) bus ();

  ew_update_sched #(
    .TILE_SIZE(4), .W(16), .S_ADDR_W(10), .N_REQ(N_REQ),
    .TILES_PER_STEP(16), .STEP_W(16), .OUTSTANDING(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .cfg_clear (cfg_clear),
    .step_done (step_done),
    .step_cnt  (step_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: optional in-order update-stage model, returns at the next negedge.
  task automatic step();
    logic upd_hs, res_hs;
    logic [63:0] cap;
    #1;
    upd_hs = bus.upd_valid && bus.upd_ready;
    res_hs = bus.res_valid && bus.res_ready;
    cap    = bus.upd_u;
    @(posedge clk);
    #1;
    if (auto_stage) begin
      if (res_hs && stage_q.size() > 0) void'(stage_q.pop_front());
      if (upd_hs) stage_q.push_back(cap);
    end
    @(negedge clk);
    if (auto_stage) begin
      bus.res_valid = (stage_q.size() > 0);
      if (stage_q.size() > 0) bus.res_s = stage_q[0];
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    cfg_clear     = 1'b0;
    auto_stage    = 1'b1;
    bus.req_valid = '0;
    bus.req_lam   = {LAM1, LAM0};
    bus.req_u     = {U1, U0};
    bus.upd_ready = 1'b1;
    bus.res_valid = 1'b0;
    bus.res_s     = '0;
    bus.rsp_ready = 2'b11;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_upd_valid", 64'(bus.upd_valid), 64'd0);
    chk("rst_upd_addr", 64'(bus.upd_addr), 64'd0);
    chk("rst_upd_lam", bus.upd_lam, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_ready", 64'(bus.res_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_step_cnt", 64'(step_cnt), 64'd0);
    chk("rst_step_done", 64'(step_done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single requester, 17 back-to-back tiles: address wraps, one step completes
    bus.req_valid = 2'b01;
    for (int k = 0; k < 17; k++) begin
      #1 chk("t1_req_ready", 64'(bus.req_ready), 64'd1);
      step();
      chk("t1_upd_addr", 64'(bus.upd_addr), 64'(k % 16));
      chk("t1_upd_valid", 64'(bus.upd_valid), 64'd1);
      chk("t1_step_done", 64'(step_done), (k == 15) ? 64'd1 : 64'd0);
    end
    chk("t1_upd_u", bus.upd_u, U0);
    chk("t1_step_cnt", 64'(step_cnt), 64'h0000_0001);
    bus.req_valid = 2'b00;
    repeat (4) step();
    chk("t1_busy_drained", 64'(busy), 64'd0);

    // Mid-operation reset clears counters
    rst_n = 1'b0;
    stage_q.delete();
    bus.res_valid = 1'b0;
    @(negedge clk);
    chk("rst2_step_cnt", 64'(step_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters valid: alternating grants
    exp_addr = '{10'd0, 10'd16, 10'd1, 10'd17, 10'd2, 10'd18};
    exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    bus.req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1 chk("t2_req_ready", 64'(bus.req_ready), 64'(exp_gnt[k]));
      step();
      chk("t2_upd_addr", 64'(bus.upd_addr), 64'(exp_addr[k]));
    end
    bus.req_valid = 2'b00;
    repeat (4) step();
    chk("t2_busy_drained", 64'(busy), 64'd0);

    // Back-pressure: outputs held, no grants, no counter movement
    bus.upd_ready = 1'b0;
    bus.req_valid = 2'b01;
    #1 chk("t3_first_ready", 64'(bus.req_ready), 64'd1);
    step();
    chk("t3_addr_first", 64'(bus.upd_addr), 64'd3);
    bus.req_lam = {LAM0, LAM1};
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_req_ready_stall", 64'(bus.req_ready), 64'd0);
      step();
      chk("t3_addr_hold", 64'(bus.upd_addr), 64'd3);
      chk("t3_lam_hold", bus.upd_lam, LAM0);
      chk("t3_valid_hold", 64'(bus.upd_valid), 64'd1);
    end
    bus.upd_ready = 1'b1;
    #1 chk("t3_release_ready", 64'(bus.req_ready), 64'd1);
    step();
    chk("t3_addr_next", 64'(bus.upd_addr), 64'd4);
    chk("t3_lam_new", bus.upd_lam, LAM1);
    bus.req_valid = 2'b00;
    bus.req_lam   = {LAM1, LAM0};
    repeat (4) step();
    chk("t3_busy_drained", 64'(busy), 64'd0);

    // FIFO full: 4 issued with no results, 5th waits for the pop cycle
    auto_stage = 1'b0;
    bus.res_valid = 1'b0;
    exp_addr[0:3] = '{10'd19, 10'd5, 10'd20, 10'd6};
    exp_gnt[0:3]  = '{2'b10, 2'b01, 2'b10, 2'b01};
    bus.req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_req_ready", 64'(bus.req_ready), 64'(exp_gnt[k]));
      step();
      chk("t4_upd_addr", 64'(bus.upd_addr), 64'(exp_addr[k]));
    end
    #1 chk("t4_full_block", 64'(bus.req_ready), 64'd0);
    step();
    chk("t4_full_no_issue", 64'(bus.upd_valid), 64'd0);
    bus.res_valid = 1'b1;
    bus.res_s     = RS;
    #1;
    chk("t4_pop_rsp_valid", 64'(bus.rsp_valid), 64'b10);
    chk("t4_pop_res_ready", 64'(bus.res_ready), 64'd1);
    chk("t4_pop_grant", 64'(bus.req_ready), 64'b10);
    chk("t4_rsp_s", bus.rsp_s, RS);
    step();
    chk("t4_fifth_addr", 64'(bus.upd_addr), 64'd21);
    chk("t4_fifth_valid", 64'(bus.upd_valid), 64'd1);
    bus.req_valid = 2'b00;
    exp_gnt[0:3] = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_rsp_order", 64'(bus.rsp_valid), 64'(exp_gnt[k]));
      step();
    end
    bus.res_valid = 1'b0;
    step();
    chk("t4_busy_drained", 64'(busy), 64'd0);

    // Head requester not ready: result stalls
    bus.req_valid = 2'b10;
    #1 chk("t5_req_ready", 64'(bus.req_ready), 64'b10);
    step();
    chk("t5_upd_addr", 64'(bus.upd_addr), 64'd22);
    bus.req_valid = 2'b00;
    step();
    bus.res_valid = 1'b1;
    bus.rsp_ready = 2'b01;
    #1;
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'b10);
    chk("t5_res_ready_low", 64'(bus.res_ready), 64'd0);
    repeat (2) step();
    #1;
    chk("t5_still_valid", 64'(bus.rsp_valid), 64'b10);
    chk("t5_still_stalled", 64'(bus.res_ready), 64'd0);
    chk("t5_busy_stalled", 64'(busy), 64'd1);
    bus.rsp_ready = 2'b11;
    #1 chk("t5_res_ready_high", 64'(bus.res_ready), 64'd1);
    step();
    bus.res_valid = 1'b0;
    chk("t5_busy_drained", 64'(busy), 64'd0);

    // cfg_clear with two tiles in flight
    bus.req_valid = 2'b11;
    #1 chk("t6_g0_ready", 64'(bus.req_ready), 64'b01);
    step();
    chk("t6_g0_addr", 64'(bus.upd_addr), 64'd7);
    #1 chk("t6_g1_ready", 64'(bus.req_ready), 64'b10);
    step();
    chk("t6_g1_addr", 64'(bus.upd_addr), 64'd23);
    cfg_clear = 1'b1;
    #1 chk("t6_clr_block0", 64'(bus.req_ready), 64'd0);
    step();
    bus.res_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1 chk("t6_clr_block_drain", 64'(bus.req_ready), 64'd0);
      step();
    end
    bus.res_valid = 1'b0;
    #1 chk("t6_clr_block_last", 64'(bus.req_ready), 64'd0);
    step();
    chk("t6_clr_busy", 64'(busy), 64'd0);
    chk("t6_clr_step_cnt", 64'(step_cnt), 64'd0);
    cfg_clear = 1'b0;
    #1 chk("t6_after_ready0", 64'(bus.req_ready), 64'b01);
    step();
    chk("t6_after_addr0", 64'(bus.upd_addr), 64'd0);
    #1 chk("t6_after_ready1", 64'(bus.req_ready), 64'b10);
    step();
    chk("t6_after_addr1", 64'(bus.upd_addr), 64'd16);
    bus.req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
